// File: rtl/stack_program_sequencer.sv
// Program sequencer with a call/return hardware stack, pipeline hold and sticky stack-error flags.
// Optional build macro STACK_OVF_TRAP_EN: an overflowing call vectors to TRAP_VEC instead of its target.
module stack_program_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                JMP_W       = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = 8'hF0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             hold,
  input  logic                             jmp,
  input  logic                             jmp_nz,
  input  logic                             dont_jmp,
  input  logic                             call,
  input  logic                             ret,
  input  logic [JMP_W-1:0]                 jmp_addr,
  output logic [ADDR_W-1:0]                pm_addr,
  output logic [ADDR_W-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
  output logic                             stack_ovf,
  output logic                             stack_unf
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

`ifdef STACK_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] ovf_target;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              stack_empty;
  logic              stack_full;
  logic              do_push;
  logic              do_pop;
  logic              set_ovf;
  logic              set_unf;

  // Jump field lands in the most significant address bits.
  assign target      = ADDR_W'(jmp_addr) << (ADDR_W - JMP_W);
  assign inc         = pc + 1'b1;
  assign stack_empty = (stack_depth == '0);
  assign stack_full  = (stack_depth == DEPTH_W'(STACK_DEPTH));
  assign top_idx     = IDX_W'(stack_depth - 1'b1);
  assign push_idx    = IDX_W'(stack_depth);
  assign top         = stack_mem[top_idx];
  assign ovf_target  = TRAP_EN ? TRAP_VEC : target;

  always_comb begin
    pm_addr = inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (reset) begin
      pm_addr = '0;
    end else if (hold) begin
      pm_addr = pc;
    end else if (ret) begin
      if (stack_empty) begin
        set_unf = 1'b1;
        pm_addr = inc;
      end else begin
        do_pop  = 1'b1;
        pm_addr = top;
      end
    end else if (call) begin
      if (stack_full) begin
        set_ovf = 1'b1;
        pm_addr = ovf_target;
      end else begin
        do_push = 1'b1;
        pm_addr = target;
      end
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pm_addr = target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      stack_depth <= '0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      pc <= pm_addr;
      if (do_push) begin
        stack_depth <= stack_depth + 1'b1;
      end else if (do_pop) begin
        stack_depth <= stack_depth - 1'b1;
      end
      if (set_ovf) begin
        stack_ovf <= 1'b1;
      end
      if (set_unf) begin
        stack_unf <= 1'b1;
      end
    end
  end

  // Stack contents need no reset; the depth counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[push_idx] <= inc;
    end
  end

endmodule
